// File: rtl/agen_tlb_pipe.sv
// Address generation + 8-entry fully-associative TLB stage feeding the memory pipe.
// Splits word-crossing accesses into two parts and holds the uop under downstream stall.

module agen_tlb_cam (
  input  logic        vld,
  input  logic [19:0] vpn,
  input  logic [19:0] qvpn,
  output logic        hit
);
  assign hit = vld && (vpn == qvpn);
endmodule

module agen_tlb_pipe #(
  parameter  int TLB_ENTRIES = 8,
  parameter  int PA_W        = 15,
  localparam int IDX_W       = $clog2(TLB_ENTRIES),
  localparam int PPN_W       = PA_W - 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_v,
  input  logic [31:0]       i_EIP,
  input  logic [31:0]       i_seg_base,
  input  logic [31:0]       i_base,
  input  logic [31:0]       i_index,
  input  logic [1:0]        i_scale,
  input  logic [31:0]       i_disp,
  input  logic [1:0]        i_opSize,
  input  logic              i_memRen,
  input  logic              i_memWen,
  input  logic              i_inv,
  input  logic              mem_stall,
  input  logic              part_ack,
  input  logic              tlb_we,
  input  logic [IDX_W-1:0]  tlb_widx,
  input  logic [19:0]       tlb_wvpn,
  input  logic [PPN_W-1:0]  tlb_wppn,
  input  logic              tlb_wvalid,
  input  logic              tlb_wwr,
  output logic              o_v,
  output logic [31:0]       o_EIP,
  output logic [PA_W-1:0]   o_phys_addr,
  output logic [1:0]        o_reqSize,
  output logic              o_spill,
  output logic              o_false_of,
  output logic              o_memRen,
  output logic              o_memWen,
  output logic              o_pf,
  output logic              stall_out
);
  typedef struct packed {
    logic [31:0] ea;
    logic [1:0]  size;
    logic        ren;
    logic        wen;
    logic [31:0] eip;
  } uop_t;

  typedef enum logic {P1, P2} state_t;

  state_t state;
  logic   vld;
  uop_t   uop;

  logic [TLB_ENTRIES-1:0][19:0]      tlb_vpn;
  logic [TLB_ENTRIES-1:0][PPN_W-1:0] tlb_ppn;
  logic [TLB_ENTRIES-1:0]            tlb_vld, tlb_wr, hit_vec;

  logic [31:0]      ea_c, va;
  logic [1:0]       size_c, req_size;
  logic [2:0]       end_off;
  logic             mem_op, spill, pf, hit, hit_wr;
  logic [PPN_W-1:0] hit_ppn;

  assign ea_c   = i_seg_base + i_base + (i_index << i_scale) + i_disp;
  // size code 2 is illegal and behaves as a 4-byte access
  assign size_c = {i_opSize[1], i_opSize[1] | i_opSize[0]};

  assign mem_op  = uop.ren | uop.wen;
  assign end_off = {1'b0, uop.ea[1:0]} + {1'b0, uop.size};
  assign spill   = vld && mem_op && end_off[2];
  assign va      = (state == P2) ? {uop.ea[31:2] + 30'd1, 2'b00} : uop.ea;

  // second part carries the bytes past the word boundary: end_off - 4
  always_comb begin
    req_size = uop.size;
    if (state == P2)  req_size = end_off[1:0];
    else if (spill)   req_size = 2'd3 - uop.ea[1:0];
  end

  generate
    for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_cam
      agen_tlb_cam u_cam (.vld(tlb_vld[g]), .vpn(tlb_vpn[g]), .qvpn(va[31:12]), .hit(hit_vec[g]));
    end
  endgenerate

  // scan high to low so the lowest hitting index ends up selected
  always_comb begin
    hit     = 1'b0;
    hit_wr  = 1'b0;
    hit_ppn = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit     = 1'b1;
        hit_wr  = tlb_wr[i];
        hit_ppn = tlb_ppn[i];
      end
    end
  end

  assign pf = vld && mem_op && (!hit || (uop.wen && !hit_wr));

  assign o_v         = vld;
  assign o_EIP       = uop.eip;
  assign o_phys_addr = (vld && !pf) ? {hit_ppn, va[11:0]} : '0;
  assign o_reqSize   = vld ? req_size : 2'd0;
  assign o_spill     = spill;
  assign o_false_of  = vld && (uop.ea[1:0] != 2'd0);
  assign o_memRen    = vld && uop.ren && !pf;
  assign o_memWen    = vld && uop.wen && !pf;
  assign o_pf        = pf;
  assign stall_out   = mem_stall || (state == P2) || (spill && state == P1);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= 1'b0;
      uop   <= '0;
      state <= P1;
    end else begin
      if (i_inv)                         vld <= 1'b0;
      else if (state == P2 && !mem_stall) vld <= 1'b0;
      else if (!stall_out)               vld <= i_v;
      if (!stall_out)
        uop <= '{ea: ea_c, size: size_c, ren: i_memRen, wen: i_memWen, eip: i_EIP};
      if (i_inv) state <= P1;
      else begin
        case (state)
          P1: if (vld && spill && part_ack) state <= P2;
          P2: if (!mem_stall)               state <= P1;
          default:                          state <= P1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tlb_vld <= '0;
      tlb_wr  <= '0;
      tlb_vpn <= '0;
      tlb_ppn <= '0;
    end else if (tlb_we) begin
      tlb_vld[tlb_widx] <= tlb_wvalid;
      tlb_wr[tlb_widx]  <= tlb_wwr;
      tlb_vpn[tlb_widx] <= tlb_wvpn;
      tlb_ppn[tlb_widx] <= tlb_wppn;
    end
  end
endmodule

// File: tb/tb_agen_tlb_pipe.sv
// Bench for agen_tlb_pipe: vector table, directed multi-cycle sequences,
// and randomized uops checked against a byte-level translation model.

module tb_agen_tlb_pipe;
  logic        clk = 0, rst = 1;
  logic        i_v = 0, i_memRen = 0, i_memWen = 0, i_inv = 0, mem_stall = 0, part_ack = 0;
  logic [31:0] i_EIP = 0, i_seg_base = 0, i_base = 0, i_index = 0, i_disp = 0;
  logic [1:0]  i_scale = 0, i_opSize = 0;
  logic        tlb_we = 0, tlb_wvalid = 0, tlb_wwr = 0;
  logic [2:0]  tlb_widx = 0, tlb_wppn = 0;
  logic [19:0] tlb_wvpn = 0;
  logic        o_v, o_spill, o_false_of, o_memRen, o_memWen, o_pf, stall_out;
  logic [31:0] o_EIP;
  logic [14:0] o_phys_addr;
  logic [1:0]  o_reqSize;

  int errors = 0, checks = 0;

  agen_tlb_pipe dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_EIP(i_EIP), .i_seg_base(i_seg_base),
    .i_base(i_base), .i_index(i_index), .i_scale(i_scale), .i_disp(i_disp),
    .i_opSize(i_opSize), .i_memRen(i_memRen), .i_memWen(i_memWen), .i_inv(i_inv),
    .mem_stall(mem_stall), .part_ack(part_ack), .tlb_we(tlb_we), .tlb_widx(tlb_widx),
    .tlb_wvpn(tlb_wvpn), .tlb_wppn(tlb_wppn), .tlb_wvalid(tlb_wvalid), .tlb_wwr(tlb_wwr),
    .o_v(o_v), .o_EIP(o_EIP), .o_phys_addr(o_phys_addr), .o_reqSize(o_reqSize),
    .o_spill(o_spill), .o_false_of(o_false_of), .o_memRen(o_memRen), .o_memWen(o_memWen),
    .o_pf(o_pf), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference TLB contents
  logic [19:0] m_vpn [8];
  logic [2:0]  m_ppn [8];
  bit          m_v [8];
  bit          m_w [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tlb_write(input int idx, input logic [19:0] vpn, input logic [2:0] ppn,
                           input bit v, input bit w);
    tlb_we = 1; tlb_widx = 3'(idx); tlb_wvpn = vpn; tlb_wppn = ppn; tlb_wvalid = v; tlb_wwr = w;
    tick;
    tlb_we = 0;
    m_vpn[idx] = vpn; m_ppn[idx] = ppn; m_v[idx] = v; m_w[idx] = w;
  endtask

  task automatic set_uop(input logic [31:0] seg, base, idx, input logic [1:0] sc,
                         input logic [31:0] disp, input logic [1:0] sz, input bit ren, wen,
                         input logic [31:0] eip);
    i_v = 1; i_seg_base = seg; i_base = base; i_index = idx; i_scale = sc; i_disp = disp;
    i_opSize = sz; i_memRen = ren; i_memWen = wen; i_EIP = eip;
  endtask

  task automatic clr_uop;
    i_v = 0; i_seg_base = 0; i_base = 0; i_index = 0; i_scale = 0; i_disp = 0;
    i_opSize = 0; i_memRen = 0; i_memWen = 0; i_EIP = 0;
  endtask

  task automatic issue_ea(input logic [31:0] ea, input logic [1:0] sz, input bit ren, wen);
    set_uop(0, ea, 0, 0, 0, sz, ren, wen, ea ^ 32'hCAFE0000);
    tick;
    clr_uop;
  endtask

  // Expected view of one part of an access, reasoned in bytes and pages.
  task automatic model(input logic [31:0] ea, input int sz, input bit ren, wen, part2,
                       output logic [14:0] pa, output bit pa_known, output int rs,
                       output bit sp, fo, pf);
    int nb, off;
    logic [31:0] va;
    bit mem, hit, wr;
    logic [2:0] ppn;
    nb  = (sz == 2) ? 4 : sz + 1;
    off = int'(ea % 4);
    mem = ren || wen;
    sp  = mem && (off + nb > 4);
    fo  = (off != 0);
    if (!part2) begin
      va = ea;
      rs = sp ? (4 - off) - 1 : nb - 1;
    end else begin
      va = (ea / 4 + 1) * 4;
      rs = nb - (4 - off) - 1;
    end
    hit = 0; wr = 0; ppn = 0;
    for (int i = 0; i < 8; i++)
      if (!hit && m_v[i] && m_vpn[i] == va[31:12]) begin
        hit = 1; ppn = m_ppn[i]; wr = m_w[i];
      end
    pf       = mem && (!hit || (wen && !wr));
    pa_known = hit || pf;
    pa       = (pf || !hit) ? 15'h0 : {ppn, va[11:0]};
  endtask

  task automatic check_model(input string tag, input logic [31:0] ea, input int sz,
                             input bit ren, wen, part2);
    logic [14:0] pa; bit known, sp, fo, pf; int rs;
    model(ea, sz, ren, wen, part2, pa, known, rs, sp, fo, pf);
    chk({tag, ".v"}, o_v, 1);
    if (known) chk({tag, ".pa"}, o_phys_addr, pa);
    chk({tag, ".rs"}, o_reqSize, rs);
    chk({tag, ".spill"}, o_spill, sp);
    chk({tag, ".fo"}, o_false_of, fo);
    chk({tag, ".pf"}, o_pf, pf);
    chk({tag, ".ren"}, o_memRen, ren && !pf);
    chk({tag, ".wen"}, o_memWen, wen && !pf);
  endtask

  typedef struct {
    logic [31:0] seg, base, idx;
    logic [1:0]  sc;
    logic [31:0] disp;
    logic [1:0]  sz;
    logic        ren, wen;
    logic [14:0] pa;
    logic [1:0]  rs;
    logic        sp, fo, pf;
  } vec_t;

  vec_t tv[11];

  initial begin
    tv[0]  = '{32'h0,   32'h1000,     32'h0,  2'd0, 32'h34,   2'd3, 1'b1, 1'b0, 15'h5034, 2'd3, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{32'h800, 32'h800,      32'h10, 2'd2, 32'h1,    2'd1, 1'b1, 1'b0, 15'h5041, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{32'h0,   32'h1036,     32'h0,  2'd0, 32'h0,    2'd3, 1'b1, 1'b0, 15'h5036, 2'd1, 1'b1, 1'b1, 1'b0};
    tv[3]  = '{32'h0,   32'h3010,     32'h0,  2'd0, 32'h0,    2'd1, 1'b0, 1'b1, 15'h0,    2'd1, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{32'h0,   32'h3000,     32'h4,  2'd2, 32'h0,    2'd0, 1'b1, 1'b0, 15'h2010, 2'd0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{32'h0,   32'h7000,     32'h0,  2'd0, 32'h0,    2'd3, 1'b1, 1'b0, 15'h0,    2'd3, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{32'h0,   32'h1003,     32'h0,  2'd0, 32'h0,    2'd3, 1'b0, 1'b0, 15'h5003, 2'd3, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{32'h0,   32'h1002,     32'h0,  2'd0, 32'h0,    2'd2, 1'b1, 1'b0, 15'h5002, 2'd1, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{32'h0,   32'hFFFFF000, 32'h0,  2'd0, 32'h2000, 2'd0, 1'b1, 1'b0, 15'h5000, 2'd0, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{32'h0,   32'h1003,     32'h0,  2'd0, 32'h0,    2'd0, 1'b0, 1'b1, 15'h5003, 2'd0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{32'h0,   32'h1003,     32'h0,  2'd0, 32'h0,    2'd1, 1'b1, 1'b0, 15'h5003, 2'd0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin m_vpn[i] = 0; m_ppn[i] = 0; m_v[i] = 0; m_w[i] = 0; end

    // reset state
    tick; tick;
    rst = 0;
    chk("rst.v", o_v, 0);
    chk("rst.pa", o_phys_addr, 0);
    chk("rst.rs", o_reqSize, 0);
    chk("rst.spill", o_spill, 0);
    chk("rst.fo", o_false_of, 0);
    chk("rst.ren", o_memRen, 0);
    chk("rst.wen", o_memWen, 0);
    chk("rst.pf", o_pf, 0);
    chk("rst.eip", o_EIP, 0);
    chk("rst.stall", stall_out, 0);

    tlb_write(2, 20'h00001, 3'd5, 1, 1);
    tlb_write(4, 20'h00003, 3'd2, 1, 0);

    // vector table
    for (int k = 0; k < 11; k++) begin
      set_uop(tv[k].seg, tv[k].base, tv[k].idx, tv[k].sc, tv[k].disp, tv[k].sz,
              tv[k].ren, tv[k].wen, 32'h100 + k);
      tick;
      clr_uop;
      chk($sformatf("tv%0d.v", k), o_v, 1);
      chk($sformatf("tv%0d.pa", k), o_phys_addr, tv[k].pa);
      chk($sformatf("tv%0d.rs", k), o_reqSize, tv[k].rs);
      chk($sformatf("tv%0d.spill", k), o_spill, tv[k].sp);
      chk($sformatf("tv%0d.fo", k), o_false_of, tv[k].fo);
      chk($sformatf("tv%0d.pf", k), o_pf, tv[k].pf);
      chk($sformatf("tv%0d.ren", k), o_memRen, tv[k].ren && !tv[k].pf);
      chk($sformatf("tv%0d.wen", k), o_memWen, tv[k].wen && !tv[k].pf);
      chk($sformatf("tv%0d.eip", k), o_EIP, 32'h100 + k);
      chk($sformatf("tv%0d.stall", k), stall_out, tv[k].sp);
      if (tv[k].sp) begin
        part_ack = 1; tick; part_ack = 0; tick;
      end
    end

    // two-part spill held by mem_stall
    issue_ea(32'h1036, 2'd3, 1, 0);
    chk("sp.p1.pa", o_phys_addr, 15'h5036);
    chk("sp.p1.stall", stall_out, 1);
    mem_stall = 1; part_ack = 1; tick; part_ack = 0;
    chk("sp.p2.pa", o_phys_addr, 15'h5038);
    chk("sp.p2.rs", o_reqSize, 1);
    chk("sp.p2.stall", stall_out, 1);
    tick;
    chk("sp.p2hold.pa", o_phys_addr, 15'h5038);
    mem_stall = 0; tick;
    chk("sp.done.v", o_v, 0);
    chk("sp.done.stall", stall_out, 0);

    // page-crossing spill, second page unmapped
    issue_ea(32'h1FFE, 2'd3, 1, 0);
    chk("pc.p1.pa", o_phys_addr, 15'h5FFE);
    chk("pc.p1.rs", o_reqSize, 1);
    chk("pc.p1.pf", o_pf, 0);
    mem_stall = 1; part_ack = 1; tick; part_ack = 0;
    chk("pc.p2.pf", o_pf, 1);
    chk("pc.p2.ren", o_memRen, 0);
    chk("pc.p2.v", o_v, 1);
    chk("pc.p2.pa", o_phys_addr, 0);
    mem_stall = 0; tick;

    // write fault; same-cycle TLB rewrite is not visible until the next edge
    issue_ea(32'h3010, 2'd3, 0, 1);
    chk("wf.pf", o_pf, 1);
    chk("wf.wen", o_memWen, 0);
    tlb_we = 1; tlb_widx = 3'd4; tlb_wvpn = 20'h00003; tlb_wppn = 3'd2; tlb_wvalid = 1; tlb_wwr = 1;
    set_uop(0, 32'h3010, 0, 0, 0, 2'd3, 0, 1, 32'h77);
    #1;
    chk("wf.same.pf", o_pf, 1);
    tick;
    tlb_we = 0; clr_uop;
    m_w[4] = 1;
    chk("wf.next.pf", o_pf, 0);
    chk("wf.next.wen", o_memWen, 1);
    chk("wf.next.pa", o_phys_addr, 15'h2010);

    // flush in P2, then stall blocks capture
    issue_ea(32'h1036, 2'd3, 1, 0);
    mem_stall = 1; part_ack = 1; tick; part_ack = 0;
    i_inv = 1; tick; i_inv = 0;
    chk("fl.v", o_v, 0);
    chk("fl.stall", stall_out, 1);
    chk("fl.pa", o_phys_addr, 0);
    set_uop(0, 32'h1020, 0, 0, 0, 2'd3, 1, 0, 32'h55);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("fl.hold%0d.v", c), o_v, 0);
    end
    mem_stall = 0; #1;
    chk("fl.rel.stall", stall_out, 0);
    tick; clr_uop;
    chk("fl.cap.v", o_v, 1);
    chk("fl.cap.pa", o_phys_addr, 15'h5020);

    // held uop stays stable while stalled
    issue_ea(32'h1010, 2'd3, 1, 0);
    mem_stall = 1;
    set_uop(0, 32'h1024, 0, 0, 0, 2'd3, 1, 0, 32'hBBBB);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("hd%0d.pa", c), o_phys_addr, 15'h5010);
      chk($sformatf("hd%0d.eip", c), o_EIP, 32'h1010 ^ 32'hCAFE0000);
    end
    mem_stall = 0; tick; clr_uop;
    chk("hd.new.pa", o_phys_addr, 15'h5024);
    chk("hd.new.eip", o_EIP, 32'hBBBB);

    // duplicate hits: lowest index wins
    tlb_write(1, 20'h00001, 3'd3, 1, 1);
    tlb_write(6, 20'h00001, 3'd7, 1, 1);
    issue_ea(32'h1234, 2'd3, 1, 0);
    chk("dup.ppn", o_phys_addr[14:12], 3);

    // randomized uops against the model
    for (int i = 0; i < 8; i++)
      tlb_write(i, 20'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    for (int it = 0; it < 60; it++) begin
      logic [31:0] tgt, seg, base, idx, disp;
      logic [1:0] sc;
      int sz; bit ren, wen;
      logic [14:0] pa; bit known, sp, fo, pf; int rs;
      tlb_write($urandom_range(0, 7), 20'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      tgt = $urandom_range(0, 32'h4FFF);
      sz  = $urandom_range(0, 3);
      ren = 1'($urandom_range(0, 1));
      wen = 1'($urandom_range(0, 1));
      seg = $urandom; base = $urandom; idx = $urandom_range(0, 255); sc = 2'($urandom_range(0, 3));
      disp = tgt - seg - base - (idx << sc);
      set_uop(seg, base, idx, sc, disp, 2'(sz), ren, wen, tgt);
      tick; clr_uop;
      check_model($sformatf("r%0d.p1", it), tgt, sz, ren, wen, 0);
      model(tgt, sz, ren, wen, 0, pa, known, rs, sp, fo, pf);
      if (sp) begin
        mem_stall = 1; part_ack = 1; tick; part_ack = 0;
        check_model($sformatf("r%0d.p2", it), tgt, sz, ren, wen, 1);
        chk($sformatf("r%0d.p2.stall", it), stall_out, 1);
        mem_stall = 0; tick;
        chk($sformatf("r%0d.ret.v", it), o_v, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
